// File: rtl/sdu_rx_avg_if.sv
// sdu_rx_avg_if: ADC capture input and averaged-sample output stream of the RX averager.
interface sdu_rx_avg_if #(
    parameter int ADC_W = 16,
    parameter int ACC_W = 32
);
    logic             trig;
    logic [ADC_W-1:0] adc_in;
    logic             adc_valid;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    modport master (output trig, adc_in, adc_valid, out_ready, input out_data, out_valid);
    modport slave  (input trig, adc_in, adc_valid, out_ready, output out_data, out_valid);
endinterface

// File: rtl/sdu_rx_avg.sv
// sdu_rx_avg: coherent-averaging RX buffer; accumulates num_avg shots in RAM and streams scaled sums.
module sdu_rx_avg #(
    parameter int ADC_W  = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   rec_len,
    input  logic [7:0]        num_avg,
    input  logic [4:0]        out_shift,
    sdu_rx_avg_if.slave       io,
    output logic              busy,
    output logic              shot_done,
    output logic              run_done,
    output logic              overflow
);
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [7:0]          navg_q, navg_d;
    logic [4:0]          shift_q, shift_d;
    logic [ADDR_W:0]     cap_cnt_q, cap_cnt_d;
    logic [7:0]          shot_cnt_q, shot_cnt_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]     out_cnt_q, out_cnt_d;
    logic                s1_vld_q, s1_vld_d;
    logic                s1_first_q, s1_first_d;
    logic                s1_last_q, s1_last_d;
    logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d;
    logic [ADC_W-1:0]    s1_smp_q, s1_smp_d;
    logic                drn_vld_q, drn_vld_d;
    logic [ACC_W-1:0]    f0_q, f0_d, f1_q, f1_d;
    logic [1:0]          fcnt_q, fcnt_d;
    logic                ovf_q, ovf_d;
    logic                shot_done_q, shot_done_d;
    logic                run_done_q, run_done_d;

    logic [ACC_W-1:0]    mem [2**ADDR_W];
    logic [ACC_W-1:0]    rd_data_q;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_en;

    logic                cap_fire, cap_last, pop, out_last, drn_issue;
    logic [1:0]          occ;
    logic [ACC_W:0]      acc_ext, smp_ext, sum;
    logic                sat;
    logic [ACC_W-1:0]    wr_data;
    logic signed [ACC_W-1:0] shifted;

    assign cap_fire  = (state_q == CAPTURE) & io.adc_valid;
    assign cap_last  = cap_fire & (cap_cnt_q == len_q - 1'b1);
    assign pop       = io.out_valid & io.out_ready;
    assign out_last  = pop & (out_cnt_q == len_q - 1'b1);
    // words held in the skid buffer plus the one in flight from RAM never exceed two
    assign occ       = fcnt_q + {1'b0, drn_vld_q};
    assign drn_issue = (state_q == DRAIN) & (rd_cnt_q < len_q) & ((occ < 2'd2) | pop);

    assign rd_addr = (state_q == CAPTURE) ? cap_cnt_q[ADDR_W-1:0] : rd_cnt_q[ADDR_W-1:0];
    assign rd_en   = cap_fire | drn_issue;

    // first shot ignores stale RAM contents, so no clear pass is needed
    assign acc_ext = s1_first_q ? '0 : {rd_data_q[ACC_W-1], rd_data_q};
    assign smp_ext = {{(ACC_W + 1 - ADC_W){s1_smp_q[ADC_W-1]}}, s1_smp_q};
    assign sum     = acc_ext + smp_ext;
    assign sat     = sum[ACC_W] != sum[ACC_W-1];
    assign wr_data = sat ? {sum[ACC_W], {(ACC_W - 1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
    assign shifted = $signed(rd_data_q) >>> shift_q;

    assign io.out_data  = f0_q;
    assign io.out_valid = fcnt_q != 2'd0;
    assign busy         = state_q != IDLE;
    assign shot_done    = shot_done_q;
    assign run_done     = run_done_q;
    assign overflow     = ovf_q;

    // accumulation RAM: write-back stage of the read-modify-write, shared synchronous read port
    always_ff @(posedge clk) begin
        if (s1_vld_q) mem[s1_addr_q] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    // next-state logic: FSM, counters, capture pipeline and 2-entry output skid buffer
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        navg_d      = navg_q;
        shift_d     = shift_q;
        cap_cnt_d   = cap_cnt_q;
        shot_cnt_d  = shot_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_cnt_d   = out_cnt_q;
        s1_vld_d    = cap_fire;
        s1_first_d  = shot_cnt_q == 8'd0;
        s1_last_d   = cap_last;
        s1_addr_d   = cap_cnt_q[ADDR_W-1:0];
        s1_smp_d    = io.adc_in;
        drn_vld_d   = drn_issue;
        ovf_d       = ovf_q | (s1_vld_q & sat);
        shot_done_d = s1_vld_q & s1_last_q;
        run_done_d  = out_last;
        f0_d        = pop ? ((fcnt_q == 2'd2) ? f1_q : shifted) : ((fcnt_q == 2'd0) ? shifted : f0_q);
        f1_d        = (drn_vld_q & (((fcnt_q == 2'd1) & ~pop) | ((fcnt_q == 2'd2) & pop))) ? shifted : f1_q;
        fcnt_d      = fcnt_q + {1'b0, drn_vld_q} - {1'b0, pop};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARM;
                    len_d      = rec_len;
                    navg_d     = (num_avg == 8'd0) ? 8'd1 : num_avg;
                    shift_d    = out_shift;
                    ovf_d      = 1'b0;
                    cap_cnt_d  = '0;
                    shot_cnt_d = '0;
                end
            end
            ARM: begin
                if (io.trig) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (cap_fire) cap_cnt_d = cap_last ? '0 : cap_cnt_q + 1'b1;
                if (cap_last) begin
                    shot_cnt_d = shot_cnt_q + 1'b1;
                    rd_cnt_d   = '0;
                    out_cnt_d  = '0;
                    state_d    = ({1'b0, shot_cnt_q} + 9'd1 < {1'b0, navg_q}) ? ARM : DRAIN;
                end
            end
            DRAIN: begin
                if (drn_issue) rd_cnt_d = rd_cnt_q + 1'b1;
                if (pop) out_cnt_d = out_cnt_q + 1'b1;
                if (out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d     = IDLE;
            cap_cnt_d   = '0;
            shot_cnt_d  = '0;
            rd_cnt_d    = '0;
            out_cnt_d   = '0;
            s1_vld_d    = 1'b0;
            drn_vld_d   = 1'b0;
            fcnt_d      = '0;
            ovf_d       = 1'b0;
            shot_done_d = 1'b0;
            run_done_d  = 1'b0;
        end
    end

    // state register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            navg_q      <= '0;
            shift_q     <= '0;
            cap_cnt_q   <= '0;
            shot_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            out_cnt_q   <= '0;
            s1_vld_q    <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_addr_q   <= '0;
            s1_smp_q    <= '0;
            drn_vld_q   <= 1'b0;
            f0_q        <= '0;
            f1_q        <= '0;
            fcnt_q      <= '0;
            ovf_q       <= 1'b0;
            shot_done_q <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            navg_q      <= navg_d;
            shift_q     <= shift_d;
            cap_cnt_q   <= cap_cnt_d;
            shot_cnt_q  <= shot_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_cnt_q   <= out_cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_addr_q   <= s1_addr_d;
            s1_smp_q    <= s1_smp_d;
            drn_vld_q   <= drn_vld_d;
            f0_q        <= f0_d;
            f1_q        <= f1_d;
            fcnt_q      <= fcnt_d;
            ovf_q       <= ovf_d;
            shot_done_q <= shot_done_d;
            run_done_q  <= run_done_d;
        end
    end
endmodule

// File: tb/tb_sdu_rx_avg.sv
// tb_sdu_rx_avg: directed and randomized runs of the RX averager against an arithmetic reference model.
module tb_sdu_rx_avg;
    localparam int ADC_W  = 16;
    localparam int ACC_W  = 18;
    localparam int ADDR_W = 5;
    localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W - 1));

    logic              clk = 1'b0;
    logic              reset, start, abort;
    logic [ADDR_W:0]   rec_len;
    logic [7:0]        num_avg;
    logic [4:0]        out_shift;
    logic              busy, shot_done, run_done, overflow;

    sdu_rx_avg_if #(.ADC_W(ADC_W), .ACC_W(ACC_W)) ifc ();

    sdu_rx_avg #(.ADC_W(ADC_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .rec_len(rec_len), .num_avg(num_avg), .out_shift(out_shift),
        .io(ifc.slave),
        .busy(busy), .shot_done(shot_done), .run_done(run_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int     checks = 0, errors = 0;
    int     sd_cnt = 0, rd_cnt = 0;
    int     smp [8][32];
    longint exp_q [32];
    logic   exp_ovf;

    always @(negedge clk) begin
        if (shot_done) sd_cnt++;
        if (run_done) rd_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_rand();
        for (int s = 0; s < 8; s++)
            for (int i = 0; i < 32; i++)
                smp[s][i] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    // reference: per-point running sum, clamped after every shot, then arithmetic shift
    task automatic model(input int len, input int nshots, input int shift);
        exp_ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            longint acc = 0;
            for (int s = 0; s < nshots; s++) begin
                acc += smp[s][i];
                if (acc > MAXV) begin acc = MAXV; exp_ovf = 1'b1; end
                if (acc < MINV) begin acc = MINV; exp_ovf = 1'b1; end
            end
            exp_q[i] = acc >>> shift;
        end
    endtask

    task automatic start_run(input int len, input int navg, input int shift);
        @(negedge clk);
        rec_len = (ADDR_W + 1)'(len); num_avg = 8'(navg); out_shift = 5'(shift); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ovf_cleared_on_start", overflow, 0);
        rec_len = 6'd3; num_avg = 8'd9; out_shift = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cap_shot(input int s, input int n);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ifc.trig = 1'b1; ifc.adc_valid = 1'b1; ifc.adc_in = 16'h5a5a;
        @(negedge clk);
        ifc.trig = 1'b0;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                ifc.adc_valid = 1'b0; ifc.adc_in = 16'($urandom);
                @(negedge clk);
            end
            ifc.adc_valid = 1'b1; ifc.adc_in = smp[s][i][15:0];
            @(negedge clk);
        end
        ifc.adc_valid = 1'b0;
    endtask

    task automatic drain(input int len, input int mode);
        int got = 0, cyc = 0, first = -1, last = -1;
        logic held_v = 1'b0;
        logic [ACC_W-1:0] held_d = '0;
        while (got < len && cyc < 4000) begin
            if (held_v) begin
                check("stall_valid", ifc.out_valid, 1);
                check("stall_data", ifc.out_data, held_d);
            end
            ifc.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            ifc.trig = 1'($urandom_range(0, 1));
            if (ifc.out_valid && ifc.out_ready) begin
                check($sformatf("word%0d", got), $signed(ifc.out_data), exp_q[got]);
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            held_v = ifc.out_valid && !ifc.out_ready;
            held_d = ifc.out_data;
            @(negedge clk);
            cyc++;
        end
        ifc.trig = 1'b0; ifc.out_ready = 1'b0;
        check("drain_words", got, len);
        if (mode == 0) check("throughput", last - first, len - 1);
    endtask

    task automatic full_run(input int len, input int navg, input int shift, input int mode);
        int sd0 = sd_cnt, rd0 = rd_cnt;
        int ns = (navg == 0) ? 1 : navg;
        model(len, ns, shift);
        start_run(len, navg, shift);
        for (int s = 0; s < ns; s++) cap_shot(s, len);
        drain(len, mode);
        @(negedge clk);
        check("busy_end", busy, 0);
        check("shot_done_count", sd_cnt - sd0, ns);
        check("run_done_count", rd_cnt - rd0, 1);
        check("overflow", overflow, exp_ovf);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; rec_len = '0; num_avg = '0; out_shift = '0;
        ifc.trig = 1'b0; ifc.adc_in = '0; ifc.adc_valid = 1'b0; ifc.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_data", ifc.out_data, 0);
        check("rst_shot_done", shot_done, 0);
        check("rst_run_done", run_done, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) smp[0][i] = i + 1;
        full_run(4, 1, 0, 0);

        for (int s = 0; s < 3; s++) for (int i = 0; i < 4; i++) smp[s][i] = 10 * (i + 1);
        full_run(4, 3, 0, 0);

        for (int s = 0; s < 8; s++) for (int i = 0; i < 4; i++) smp[s][i] = 32767;
        full_run(4, 8, 0, 0);
        check("sat_value", exp_q[0], 131071);

        for (int s = 0; s < 4; s++) begin smp[s][0] = 100; smp[s][1] = -100; end
        full_run(2, 4, 2, 1);

        fill_rand();
        full_run(16, 2, 0, 1);

        fill_rand();
        start_run(8, 3, 0);
        cap_shot(0, 8);
        cap_shot(1, 8);
        cap_shot(2, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_cap_busy", busy, 0);
        check("abort_cap_valid", ifc.out_valid, 0);
        fill_rand();
        full_run(8, 1, 0, 0);

        fill_rand();
        start_run(6, 1, 0);
        cap_shot(0, 6);
        repeat (4) @(negedge clk);
        check("drain_hold_valid", ifc.out_valid, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_drain_valid", ifc.out_valid, 0);
        check("abort_drain_busy", busy, 0);

        fill_rand();
        full_run(32, 2, 1, 2);
        for (int r = 0; r < 4; r++) begin
            fill_rand();
            full_run($urandom_range(2, 32), $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
